// File: rtl/vpu_sram_responder.sv
// Purpose: banked SRAM responder for the VPU src (read) and dst (write) req/ack beat ports.
// Latency: ack one cycle after a port is pending; read data RD_LAT cycles after the ack cycle.
// Backpressure: req is held until ack; a same-bank collision delays one port via round-robin.
module vpu_sram_responder #(
  parameter int BANK_CNT_LG2 = 3,
  parameter int DEPTH_LG2    = 6,
  parameter int DATA_WIDTH   = 512,
  parameter int RD_LAT       = 2     // legal range 1..8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    src_req,
  output logic                    src_ack,
  input  logic [BANK_CNT_LG2-1:0] src_rid,
  input  logic [DEPTH_LG2-1:0]    src_addr,
  input  logic                    src_reb,
  input  logic                    src_rlast,
  output logic [DATA_WIDTH-1:0]   src_rdata,
  output logic                    src_rvalid,
  input  logic                    dst_req,
  output logic                    dst_ack,
  input  logic [BANK_CNT_LG2-1:0] dst_wid,
  input  logic [DEPTH_LG2-1:0]    dst_addr,
  input  logic                    dst_web,
  input  logic                    dst_wlast,
  input  logic [DATA_WIDTH-1:0]   dst_wdata,
  output logic                    rd_burst_done,
  output logic                    wr_burst_done,
  output logic [15:0]             conflict_cnt
);

  localparam int IDX_W = BANK_CNT_LG2 + DEPTH_LG2;
  localparam int WORDS = 1 << IDX_W;

  // Handshake / arbitration state
  logic        src_ack_q, src_ack_d;
  logic        dst_ack_q, dst_ack_d;
  logic        rr_q, rr_d;
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic        wr_done_q, wr_done_d;

  // Read return pipeline: stage 0 is loaded at the accept edge, stage RD_LAT-1 drives the outputs
  logic [RD_LAT-1:0]     rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0]     rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0] rd_dat_q [RD_LAT];
  logic [DATA_WIDTH-1:0] rd_dat_d [RD_LAT];

  // Storage: banks are concatenated, bank id forms the upper index bits
  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [IDX_W-1:0]      mem_raddr;

  logic src_pend, dst_pend, same_bank;
  logic src_fire, dst_fire, src_rd_fire;

  // Pending and accept qualifiers; accept needs req still high while ack is up
  always_comb begin
    src_pend    = src_req & ~src_ack_q;
    dst_pend    = dst_req & ~dst_ack_q;
    same_bank   = src_pend & dst_pend & (src_rid == dst_wid);
    src_fire    = src_req & src_ack_q;
    dst_fire    = dst_req & dst_ack_q;
    src_rd_fire = src_fire & ~src_reb;
  end

  // Grant selection: both ports in parallel unless they collide on a bank, then rr picks
  always_comb begin
    src_ack_d      = src_pend;
    dst_ack_d      = dst_pend;
    rr_d           = rr_q;
    conflict_cnt_d = conflict_cnt_q;
    if (same_bank) begin
      src_ack_d = ~rr_q;
      dst_ack_d = rr_q;
      rr_d      = ~rr_q;
      if (conflict_cnt_q != 16'hFFFF) begin
        conflict_cnt_d = conflict_cnt_q + 16'd1;
      end
    end
    wr_done_d = dst_fire & dst_wlast;
  end

  // Memory write port; a null beat (web=1) is acked but leaves storage untouched
  always_comb begin
    mem_we    = dst_fire & ~dst_web;
    mem_waddr = {dst_wid, dst_addr};
    mem_wdata = dst_wdata;
    mem_raddr = {src_rid, src_addr};
  end

  // Read pipeline advance; each data stage only loads behind a valid so rdata holds when idle
  always_comb begin
    rd_vld_d     = '0;
    rd_last_d    = '0;
    rd_dat_d     = rd_dat_q;
    rd_vld_d[0]  = src_rd_fire;
    rd_last_d[0] = src_rlast;
    if (src_rd_fire) begin
      rd_dat_d[0] = mem_q[mem_raddr];
    end
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i]  = rd_vld_q[i-1];
      rd_last_d[i] = rd_last_q[i-1];
      if (rd_vld_q[i-1]) begin
        rd_dat_d[i] = rd_dat_q[i-1];
      end
    end
  end

  // Control and pipeline registers; reset clears acks so a beat acked at reset is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ack_q      <= 1'b0;
      dst_ack_q      <= 1'b0;
      rr_q           <= 1'b0;
      conflict_cnt_q <= 16'd0;
      wr_done_q      <= 1'b0;
      rd_vld_q       <= '0;
      rd_last_q      <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_dat_q[i] <= '0;
      end
    end else begin
      src_ack_q      <= src_ack_d;
      dst_ack_q      <= dst_ack_d;
      rr_q           <= rr_d;
      conflict_cnt_q <= conflict_cnt_d;
      wr_done_q      <= wr_done_d;
      rd_vld_q       <= rd_vld_d;
      rd_last_q      <= rd_last_d;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_dat_q[i] <= rd_dat_d[i];
      end
    end
  end

  // SRAM array is not reset; writes land at the accept edge
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Output drive
  always_comb begin
    src_ack       = src_ack_q;
    dst_ack       = dst_ack_q;
    src_rvalid    = rd_vld_q[RD_LAT-1];
    src_rdata     = rd_dat_q[RD_LAT-1];
    rd_burst_done = rd_vld_q[RD_LAT-1] & rd_last_q[RD_LAT-1];
    wr_burst_done = wr_done_q;
    conflict_cnt  = conflict_cnt_q;
  end

endmodule

// File: tb/tb_vpu_sram_responder.sv
// Bench for vpu_sram_responder: directed scenarios plus random two-port traffic.
// A negedge monitor holds a word-level memory model, expected-read queue and arbitration rules.
// All outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_vpu_sram_responder;

  localparam int BL = 3;
  localparam int DL = 6;
  localparam int DW = 512;
  localparam int RL = 2;
  localparam int NW = 1 << (BL + DL);

  logic          clk, rst_n;
  logic          src_req, src_ack, src_reb, src_rlast, src_rvalid;
  logic [BL-1:0] src_rid;
  logic [DL-1:0] src_addr;
  logic [DW-1:0] src_rdata;
  logic          dst_req, dst_ack, dst_web, dst_wlast;
  logic [BL-1:0] dst_wid;
  logic [DL-1:0] dst_addr;
  logic [DW-1:0] dst_wdata;
  logic          rd_burst_done, wr_burst_done;
  logic [15:0]   conflict_cnt;

  vpu_sram_responder #(.BANK_CNT_LG2(BL), .DEPTH_LG2(DL), .DATA_WIDTH(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_req(src_req), .src_ack(src_ack), .src_rid(src_rid), .src_addr(src_addr),
    .src_reb(src_reb), .src_rlast(src_rlast), .src_rdata(src_rdata), .src_rvalid(src_rvalid),
    .dst_req(dst_req), .dst_ack(dst_ack), .dst_wid(dst_wid), .dst_addr(dst_addr),
    .dst_web(dst_web), .dst_wlast(dst_wlast), .dst_wdata(dst_wdata),
    .rd_burst_done(rd_burst_done), .wr_burst_done(wr_burst_done), .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] d;
    bit            known;
    bit            last;
    int            due;
  } rd_exp_t;

  logic [DW-1:0] mmem   [NW];
  bit            mknown [NW];
  rd_exp_t       rq [$];
  bit            m_rr, g_s, g_d, m_wbd;
  logic [15:0]   m_cnt;
  int            rv_total = 0;
  int            bd_idx   = 0;
  logic [DW-1:0] last_rd;

  always @(negedge clk) begin
    bit      sp, dp, exp_rv;
    rd_exp_t e;
    if (!rst_n) begin
      chk("rst_src_ack", src_ack, 0);
      chk("rst_dst_ack", dst_ack, 0);
      chk("rst_src_rvalid", src_rvalid, 0);
      chk("rst_src_rdata", src_rdata, 0);
      chk("rst_rd_burst_done", rd_burst_done, 0);
      chk("rst_wr_burst_done", wr_burst_done, 0);
      chk("rst_conflict_cnt", conflict_cnt, 0);
      g_s = 0; g_d = 0; m_rr = 0; m_cnt = 0; m_wbd = 0;
      rq.delete();
    end else begin
      chk("src_ack", src_ack, g_s);
      chk("dst_ack", dst_ack, g_d);
      chk("conflict_cnt", conflict_cnt, m_cnt);
      chk("wr_burst_done", wr_burst_done, m_wbd);
      exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
      chk("src_rvalid", src_rvalid, exp_rv);
      if (exp_rv) begin
        e = rq.pop_front();
        if (e.known) chk("src_rdata", src_rdata, e.d);
        chk("rd_burst_done", rd_burst_done, e.last);
      end else begin
        chk("rd_burst_done_idle", rd_burst_done, 0);
      end
      if (src_rvalid) begin
        rv_total++;
        last_rd = src_rdata;
        if (rd_burst_done) bd_idx = rv_total;
      end
      // beats accepted at the coming rising edge (read sees memory before this edge's write)
      if (src_req && src_ack && !src_reb) begin
        e.d     = mmem[{src_rid, src_addr}];
        e.known = mknown[{src_rid, src_addr}];
        e.last  = src_rlast;
        e.due   = cyc + RL;
        rq.push_back(e);
      end
      if (dst_req && dst_ack && !dst_web) begin
        mmem[{dst_wid, dst_addr}]   = dst_wdata;
        mknown[{dst_wid, dst_addr}] = 1'b1;
      end
      m_wbd = dst_req && dst_ack && dst_wlast;
      // who is owed an ack next cycle
      sp = src_req && !g_s;
      dp = dst_req && !g_d;
      if (sp && dp && (src_rid == dst_wid)) begin
        g_s  = !m_rr;
        g_d  = m_rr;
        m_rr = !m_rr;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        g_s = sp;
        g_d = dp;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic rd_beat(input logic [BL-1:0] rid, input logic [DL-1:0] addr,
                         input logic reb, input logic last, output int lat);
    int t0;
    src_req = 1'b1; src_rid = rid; src_addr = addr; src_reb = reb; src_rlast = last;
    t0 = cyc; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (src_ack) begin lat = cyc - t0; break; end
    end
    chk("src_ack_seen", src_ack, 1);
    @(posedge clk); #1;
    src_req = 1'b0;
  endtask

  task automatic wr_beat(input logic [BL-1:0] wid, input logic [DL-1:0] addr,
                         input logic web, input logic last, input logic [DW-1:0] data,
                         output int lat);
    int t0;
    dst_req = 1'b1; dst_wid = wid; dst_addr = addr; dst_web = web; dst_wlast = last;
    dst_wdata = data;
    t0 = cyc; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dst_ack) begin lat = cyc - t0; break; end
    end
    chk("dst_ack_seen", dst_ack, 1);
    @(posedge clk); #1;
    dst_req = 1'b0;
  endtask

  task automatic dual(input logic [BL-1:0] rid, input logic [DL-1:0] raddr,
                      input logic [BL-1:0] wid, input logic [DL-1:0] waddr,
                      input logic [DW-1:0] data, output int ls, output int ld);
    int t0;
    src_req = 1'b1; src_rid = rid; src_addr = raddr; src_reb = 1'b0; src_rlast = 1'b0;
    dst_req = 1'b1; dst_wid = wid; dst_addr = waddr; dst_web = 1'b0; dst_wlast = 1'b0;
    dst_wdata = data;
    t0 = cyc; ls = -1; ld = -1;
    for (int i = 0; i < 40 && (ls < 0 || ld < 0); i++) begin
      @(negedge clk);
      if (src_req && src_ack) ls = cyc - t0;
      if (dst_req && dst_ack) ld = cyc - t0;
      @(posedge clk); #1;
      if (ls >= 0) src_req = 1'b0;
      if (ld >= 0) dst_req = 1'b0;
    end
  endtask

  task automatic wait_rv(output logic [DW-1:0] d, output int at);
    at = -1; d = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (src_rvalid) begin at = cyc; d = src_rdata; break; end
    end
    chk("rvalid_seen", src_rvalid, 1);
    @(posedge clk); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic master_src(input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      rd_beat(BL'($urandom_range(0, 7)), DL'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), lat);
      cycles($urandom_range(0, 2));
    end
  endtask

  task automatic master_dst(input int n);
    int lat;
    for (int i = 0; i < n; i++) begin
      wr_beat(BL'($urandom_range(0, 7)), DL'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), rnd_word(), lat);
      cycles($urandom_range(0, 2));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int            lat, ls, ld, t0, rvc, rv0;
    logic [DW-1:0] d;
    logic [DW-1:0] a5;
    a5 = {64{8'hA5}};
    src_req = 0; src_rid = 0; src_addr = 0; src_reb = 1; src_rlast = 0;
    dst_req = 0; dst_wid = 0; dst_addr = 0; dst_web = 1; dst_wlast = 0; dst_wdata = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // write then read back, RD_LAT=2
    wr_beat(3, 6'h10, 0, 0, a5, lat);
    chk("wr_ack_lat", lat, 1);
    t0 = cyc;
    rd_beat(3, 6'h10, 0, 0, lat);
    chk("rd_ack_lat", lat, 1);
    wait_rv(d, rvc);
    chk("rd_rvalid_lat", rvc - t0, 1 + RL);
    chk("rd_data_a5", d, a5);

    // different banks are served together
    dual(1, 6'h10, 2, 6'h10, rnd_word(), ls, ld);
    chk("par_src_lat", ls, 1);
    chk("par_dst_lat", ld, 1);
    @(negedge clk);
    chk("par_conflict_cnt", conflict_cnt, 0);
    @(posedge clk); #1;

    // same-bank collision twice: read wins, then write wins
    dual(5, 6'h10, 5, 6'h11, rnd_word(), ls, ld);
    chk("c1_src_lat", ls, 1);
    chk("c1_dst_lat", ld, 2);
    dual(5, 6'h12, 5, 6'h13, rnd_word(), ls, ld);
    chk("c2_dst_lat", ld, 1);
    chk("c2_src_lat", ls, 2);
    @(negedge clk);
    chk("c_conflict_cnt", conflict_cnt, 2);
    @(posedge clk); #1;

    // null beats
    wr_beat(3, 6'h10, 1, 0, '0, lat);
    chk("null_wr_ack_lat", lat, 1);
    rv0 = rv_total;
    rd_beat(3, 6'h10, 1, 0, lat);
    chk("null_rd_ack_lat", lat, 1);
    cycles(5);
    chk("null_rd_no_rvalid", rv_total - rv0, 0);
    rd_beat(3, 6'h10, 0, 0, lat);
    wait_rv(d, rvc);
    chk("null_wr_mem_kept", d, a5);

    // preload a working set for the burst and random traffic
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 8; a++)
        wr_beat(BL'(b), DL'(a), 0, 0, rnd_word(), lat);

    // 4-beat read burst, back to back
    rv0 = rv_total;
    for (int i = 0; i < 4; i++) begin
      t0 = cyc;
      rd_beat(2, DL'(i), 0, (i == 3), lat);
      if (i > 0) chk("burst_b2b_ack_lat", lat, 1);
    end
    cycles(RL + 3);
    chk("burst_rvalids", rv_total - rv0, 4);
    chk("burst_done_idx", bd_idx - rv0, 4);
    chk("burst_last_data", last_rd, mmem[{3'd2, 6'd3}]);

    // wlast: done pulse the cycle after accept, with or without web
    wr_beat(6, 6'h14, 0, 1, rnd_word(), lat);
    @(negedge clk);
    chk("wlast_done", wr_burst_done, 1);
    @(posedge clk); #1;
    wr_beat(6, 6'h15, 1, 1, rnd_word(), lat);
    @(negedge clk);
    chk("wlast_null_done", wr_burst_done, 1);
    @(posedge clk); #1;

    // reset one cycle after a read ack
    rv0 = rv_total;
    rd_beat(3, 6'h10, 0, 1, lat);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_rvalid", src_rvalid, 0);
      chk("rst_mid_rdata", src_rdata, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(4);
    chk("rst_mid_dropped", rv_total - rv0, 0);
    t0 = cyc;
    rd_beat(3, 6'h10, 0, 0, lat);
    chk("post_rst_ack_lat", lat, 1);
    wait_rv(d, rvc);
    chk("post_rst_rvalid_lat", rvc - t0, 1 + RL);
    chk("post_rst_data", d, a5);

    // random concurrent traffic on both ports
    fork
      master_src(80);
      master_dst(80);
    join
    cycles(RL + 4);
    chk("drain_queue_empty", rq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // absolute watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
